// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot multi-cycle phase sequencer with early termination, halt/resume and retired count
module phase_sequencer #(
   parameter  int NPHASE = 5,
   parameter  int CNT_W  = 16,
   localparam int IDX_W  = $clog2(NPHASE)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_ce,
   input  logic             i_last,
   input  logic             i_halt_req,
   input  logic             i_resume,
   output logic [NPHASE-1:0] o_phase,
   output logic [IDX_W-1:0]  o_phase_idx,
   output logic             o_done,
   output logic             o_halted,
   output logic [CNT_W-1:0]  o_retired
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t            r_state, w_state_n;
   logic [NPHASE-1:0] r_phase, w_phase_n;
   logic [IDX_W-1:0]  r_idx, w_idx_n;
   logic              r_done, w_done_n;
   logic [CNT_W-1:0]  r_retired, w_retired_n;
   logic              r_pending, w_pending_n;
   logic              w_adv, w_wrap, w_halt;
   assign w_adv  = (r_state == RUN) && i_ce;
   assign w_wrap = w_adv && ((r_idx == IDX_W'(NPHASE - 1)) || i_last);
   assign w_halt = r_pending || i_halt_req;
   // Next-state and next-output logic; a pending halt is only consumed by the wrap that halts
   always_comb begin
      w_state_n   = r_state;
      w_phase_n   = r_phase;
      w_idx_n     = r_idx;
      w_done_n    = 1'b0;
      w_retired_n = r_retired;
      w_pending_n = r_pending;
      if (r_state == RUN) begin
         if (w_wrap) begin
            w_retired_n = r_retired + CNT_W'(1);
            w_done_n    = 1'b1;
            w_idx_n     = '0;
            w_phase_n   = w_halt ? '0 : NPHASE'(1);
            w_state_n   = w_halt ? HALTED : RUN;
            w_pending_n = 1'b0;
         end else begin
            w_pending_n = r_pending | i_halt_req;
            w_phase_n   = i_ce ? r_phase << 1 : r_phase;
            w_idx_n     = i_ce ? r_idx + IDX_W'(1) : r_idx;
         end
      end else if (i_resume) begin
         w_state_n = RUN;
         w_phase_n = NPHASE'(1);
         w_idx_n   = '0;
      end
   end
   // State register with synchronous reset
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= RUN;
         r_phase   <= NPHASE'(1);
         r_idx     <= '0;
         r_done    <= 1'b0;
         r_retired <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_phase   <= w_phase_n;
         r_idx     <= w_idx_n;
         r_done    <= w_done_n;
         r_retired <= w_retired_n;
         r_pending <= w_pending_n;
      end
   end
   assign o_phase     = r_phase;
   assign o_phase_idx = r_idx;
   assign o_done      = r_done;
   assign o_halted    = (r_state == HALTED);
   assign o_retired   = r_retired;
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised one-hot phase sequencer for the multi-cycle processor control path. It generalises the fixed five-phase counter to NPHASE phases and supports early instruction termination, a halt/resume state, and a retired-instruction counter. It sits between the control unit and the datapath. The datapath qualifies its register enables with the phase outputs; the control unit drives early termination and halt requests.

## Interface
- NPHASE, 5, number of phases per full instruction; legal range 2..16
- CNT_W, 16, width of retired-instruction counter
- IDX_W (local), clog2(NPHASE), width of phase_idx
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- ce  in  1  advance enable; phase state holds when 0
- last_i  in  1  current phase is the final one of this instruction; sampled only on advancing edges
- halt_req  in  1  request to stop at the next instruction boundary
- resume  in  1  leave HALTED
- phase  out  NPHASE  one-hot current phase; all zero while halted
- phase_idx  out  IDX_W  binary index of active phase; 0 while halted
- done  out  1  one-cycle pulse marking instruction completion
- halted  out  1  high in HALTED state
- retired  out  CNT_W  completed-instruction count, modulo 2^CNT_W

## Operation
- States: RUN and HALTED. All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: state=RUN, phase=1 (bit 0), phase_idx=0, done=0, halted=0, retired=0, halt_pending=0.
- Advance edge: state=RUN and ce=1.
- Wrap condition on an advance edge: phase_idx==NPHASE-1 or last_i=1.
- Advance edge without wrap:
  - phase shifts left one bit; phase_idx increments.
  - done=0.
- Advance edge with wrap:
  - retired increments, wrapping from all-ones to 0.
  - done=1 for exactly that following cycle.
  - If halt_pending=1 or halt_req=1: state goes to HALTED, phase=0, phase_idx=0, halted=1, halt_pending cleared.
  - Otherwise: phase=1 and phase_idx=0.
- Non-advance edge in RUN (ce=0): phase, phase_idx and retired hold; done=0; last_i is ignored.
- halt_pending:
  - Set on any edge in RUN where halt_req=1 and no wrap occurs, regardless of ce.
  - Stays set until the wrap that enters HALTED. It is never cleared without halting.
- HALTED:
  - ce, last_i and halt_req are ignored. retired holds; done=0.
  - resume=1 (ce not required) returns to RUN on the next edge: phase=1, phase_idx=0, halted=0.
  - resume is ignored in RUN.
- last_i asserted in the final phase is equivalent to a normal wrap and produces no extra effect.
- phase is always one-hot or zero, and phase_idx always equals the bit position of phase.

## Timing
- Latency for all outputs is 1 clock from the sampling edge.
- A full instruction without last_i takes NPHASE advance edges. With last_i in phase k, it takes k+1 advance edges.
- Minimum instruction length is 1 advance edge (last_i=1 in phase 0).
- The done pulse coincides with the first cycle in which phase=1 again, or with the first cycle in which halted=1.
- Back-to-back instructions have no bubble: the wrap edge lands directly in phase 0.
- The halt boundary follows the wrap edge. Resume-to-phase-0 takes 1 cycle. The minimum HALTED dwell is 1 cycle.
- Reset mid-instruction or while halted has the next edge load the reset values; retired clears.
- Reset has priority over every other input.

## Test plan
- Free run, NPHASE=5: reset, then ce=1 for 12 cycles -> phase sequence 1,2,4,8,16,1,... with phase_idx 0..4. done is high in the cycles after the edges at cycles 5 and 10. retired=2.
- Early termination and stall: last_i=1 while phase_idx=2 -> next phase=1, done=1, retired+1. Hold ce=0 for 3 cycles in phase 2 -> phase stays 4, done=0.
- Halt: pulse halt_req for 1 cycle in phase 1 with ce toggling -> the instruction finishes; on the wrap edge halted=1, phase=0, done=1. Then with ce=1 for 5 cycles, retired is unchanged. resume=1 -> next cycle phase=1, halted=0.
- Simultaneous events: halt_req=1 and last_i=1 on the same advance edge -> HALTED next cycle, retired+1. resume=1 and halt_req=1 in HALTED -> RUN, no pending halt retained.
- Counter wrap, CNT_W=4: run 17 instructions -> retired goes 15 to 0 to 1.
- Parameter sweep NPHASE=2 and 16 with reset asserted mid-instruction -> phase=1, retired=0 the next cycle, and the one-hot/index consistency holds every cycle.
